// File: rtl/if_id_queue.sv
// IF->ID decoupling queue: DEPTH-entry circular buffer, one cycle from push to id_valid, flushable.
// With IF_ID_BYPASS_EN defined, an empty queue forwards if_* to id_* in the same cycle.
module if_id_queue #(
    parameter int          DEPTH    = 4,
    parameter int          CAUSE_W  = 7,
    parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       exception_flush,
    input  logic                       branch_flush,
    input  logic                       if_valid,
    input  logic [31:0]                if_pc,
    input  logic [31:0]                if_inst,
    input  logic                       if_is_exception,
    input  logic [CAUSE_W-1:0]         if_exception_cause,
    output logic                       if_ready,
    input  logic                       id_ready,
    output logic                       id_valid,
    output logic [31:0]                id_pc,
    output logic [31:0]                id_inst,
    output logic                       id_is_exception,
    output logic [CAUSE_W-1:0]         id_exception_cause,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [31:0]        pc;
        logic [31:0]        inst;
        logic               is_exc;
        logic [CAUSE_W-1:0] cause;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    entry_t        in_entry;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          flush;
    logic          q_valid;
    logic          bypass;
    logic          push;
    logic          pop;

    assign flush    = exception_flush | branch_flush;
    assign q_valid  = (count != '0);
    assign if_ready = (count != CW'(DEPTH));
    assign head     = mem[rd_ptr];
    assign in_entry = '{pc: if_pc, inst: if_inst, is_exc: if_is_exception, cause: if_exception_cause};

`ifdef IF_ID_BYPASS_EN
    assign bypass = rst_n & ~q_valid & if_valid & ~flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry that ID takes immediately never lands in storage.
    assign push = if_valid & if_ready & ~(bypass & id_ready);
    assign pop  = q_valid & id_ready;

    // Storage is left unreset; outputs are masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= in_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        id_valid           = q_valid | bypass;
        id_pc              = RESET_PC;
        id_inst            = '0;
        id_is_exception    = 1'b0;
        id_exception_cause = '0;
        if (q_valid) begin
            id_pc              = head.pc;
            id_inst            = head.inst;
            id_is_exception    = head.is_exc;
            id_exception_cause = head.cause;
        end else if (bypass) begin
            id_pc              = if_pc;
            id_inst            = if_inst;
            id_is_exception    = if_is_exception;
            id_exception_cause = if_exception_cause;
        end
    end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of queue entries; power of two, 2..16.
REQ-002 SHALL have parameter CAUSE_W, default 7: width of the exception-cause field.
REQ-003 SHALL have parameter RESET_PC, default 32'h1C000000: PC presented on empty or bubble output.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port exception_flush, input, 1 bit: discards all entries; highest priority.
REQ-007 SHALL have port branch_flush, input, 1 bit: discards all entries.
REQ-008 SHALL have port if_valid, input, 1 bit: IF offers an entry.
REQ-009 SHALL have port if_pc, input, 32 bits: fetch PC.
REQ-010 SHALL have port if_inst, input, 32 bits: fetched instruction.
REQ-011 SHALL have port if_is_exception, input, 1 bit: fetch-stage exception flag.
REQ-012 SHALL have port if_exception_cause, input, CAUSE_W bits: fetch-stage exception cause.
REQ-013 SHALL have port if_ready, output, 1 bit: queue accepts a push this cycle.
REQ-014 SHALL have port id_ready, input, 1 bit: ID consumes the head entry; low equals ID pause.
REQ-015 SHALL have port id_valid, output, 1 bit: head entry valid.
REQ-016 SHALL have port id_pc, output, 32 bits: head PC.
REQ-017 SHALL have port id_inst, output, 32 bits: head instruction.
REQ-018 SHALL have port id_is_exception, output, 1 bit: head exception flag.
REQ-019 SHALL have port id_exception_cause, output, CAUSE_W bits: head exception cause.
REQ-020 SHALL have port count, output, $clog2(DEPTH+1) bits: current occupancy.

Function
REQ-021 SHALL perform a push when if_valid and if_ready are both high; entry written at the write pointer.
REQ-022 SHALL perform a pop when id_valid and id_ready are both high; the read pointer advances.
REQ-023 SHALL drive if_ready = (count != DEPTH), independent of id_ready; a push into a full queue is refused even when a pop occurs in the same cycle.
REQ-024 SHALL update count as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-025 SHALL wrap read and write pointers modulo DEPTH; FIFO order preserved across wrap.
REQ-026 SHALL drive id_valid = (count != 0); the id_* data outputs come from the head entry, a combinational mux of registered state.
REQ-027 SHALL drive id_pc = RESET_PC, id_inst = 0, id_is_exception = 0 and id_exception_cause = 0 when id_valid = 0 (bubble).
REQ-028 SHALL, on exception_flush or branch_flush, set both pointers and count to 0 at the clock edge; the same-cycle push and pop are discarded; id_valid is low the next cycle.
REQ-029 SHALL give exception_flush priority over branch_flush; both high behaves as one flush.
REQ-030 SHALL hold the head entry and all outputs stable while id_ready = 0 and no flush is asserted.
REQ-031 SHALL have a latency, without bypass, of one cycle from push to id_valid.
REQ-032 SHALL accept an entry with if_is_exception = 1 and pass it through unmodified; the queue does not act on it.

Reset
REQ-033 SHALL, while rst_n = 0 and asynchronously, clear pointers and count to 0, force id_valid = 0 and drive bubble values on the id_* outputs.
REQ-034 SHALL abort any in-flight push or pop when reset is asserted mid-operation; no entry survives; if_ready = 1 after reset.
REQ-035 SHALL not reset the storage array contents; outputs are masked by id_valid.

Configuration
REQ-036 SHALL, with macro IF_ID_BYPASS_EN defined, pass if_* straight to the id_* outputs when count = 0, if_valid = 1 and no flush: id_valid = 1 in the same cycle; if id_ready = 1 the entry is consumed and not stored; count stays 0.
REQ-037 SHALL, with IF_ID_BYPASS_EN undefined, have no combinational path from the if_* inputs to the id_* outputs or id_valid.

Verification
REQ-038 SHALL cover fill/drain: DEPTH=4, push PCs 0x1C000000..0x1C00000C with id_ready=0 -> count=4, if_ready=0; then id_ready=1 -> pops in order over 4 cycles, count reaches 0.
REQ-039 SHALL cover wrap: 10 pushes interleaved with pops, count held at 2 -> output PC sequence matches input sequence exactly.
REQ-040 SHALL cover flush: count=3, branch_flush together with a push of PC 0x1C000040 -> next cycle count=0, id_pc=0x1C000000, id_valid=0.
REQ-041 SHALL cover full with simultaneous pop: count=4, if_valid=1, id_ready=1 -> pop occurs, push refused, count=3.
REQ-042 SHALL cover reset mid-stream: rst_n low for 1 ns between edges with count=2 -> immediate id_valid=0, count=0, if_ready=1.
REQ-043 SHALL cover bypass: IF_ID_BYPASS_EN defined, empty queue, push inst 0x02800C21 with id_ready=1 -> same cycle id_valid=1, id_inst=0x02800C21; count stays 0.
